// File: rtl/mha_pkg.sv
// rtl/mha_pkg.sv - shared MHA state encoding, default geometry/addresses and tile-count helper
package mha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KLOAD   = 3'd1,
        ST_QSTREAM = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } rd_state_t;

    localparam int DEF_NUM_CH       = 16;
    localparam int DEF_TOKENS       = 729;
    localparam int DEF_TILE_ROWS    = 4;
    localparam int DEF_DRAIN_CYCLES = 19;

    localparam logic [31:0] DEF_Q_BASE    = 32'h0000_0000;
    localparam logic [31:0] DEF_K_BASE    = 32'h0000_3000;
    localparam logic [31:0] DEF_CH_STRIDE = 32'h0000_0300;

    // Number of K tiles per channel; the last tile is zero-padded when tokens
    // is not a multiple of tile_rows.
    function automatic int num_ktiles(input int tok_count, input int rows);
        return (tok_count + rows - 1) / rows;
    endfunction

endpackage

// File: rtl/qkv_tile_reader_if.sv
// rtl/qkv_tile_reader_if.sv - control/issue bundle between the tile reader and its SRAM/PE consumers
interface qkv_tile_reader_if #(
    parameter int addr_width = 32
);
    logic                  start;
    logic                  hold;
    logic                  rd_en;
    logic [addr_width-1:0] rd_addr;
    logic                  is_wt;
    logic                  pad_zero;
    logic                  data_valid;
    logic                  data_is_wt;
    logic                  tile_last;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, hold,
        output rd_en, rd_addr, is_wt, pad_zero, data_valid, data_is_wt,
               tile_last, busy, done
    );

    modport slave (
        output start, hold,
        input  rd_en, rd_addr, is_wt, pad_zero, data_valid, data_is_wt,
               tile_last, busy, done
    );
endinterface

// File: rtl/qkv_tile_reader_valid_delay_line.sv
// rtl/qkv_tile_reader_valid_delay_line.sv - fixed-depth pipe aligning {rd_en, is_wt} with SRAM read data
module valid_delay_line #(
    parameter int depth = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic in_is_wt,
    output logic out_valid,
    output logic out_is_wt
);
    logic [1:0] pipe [depth];

    // Shift every cycle regardless of stalls so reads already in flight still land.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < depth; i++) pipe[i] <= 2'b00;
        end else begin
            pipe[0] <= {in_valid, in_is_wt};
            for (int i = 1; i < depth; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign out_valid = pipe[depth-1][1];
    assign out_is_wt = pipe[depth-1][0];
endmodule

// File: rtl/qkv_tile_reader.sv
// rtl/qkv_tile_reader.sv - QK_MULT read sequencer: K-tile weight rows, Q token stream, drain, per channel
module qkv_tile_reader
    import mha_pkg::*;
#(
    parameter int                    addr_width   = 32,
    parameter int                    num_ch       = DEF_NUM_CH,
    parameter int                    tokens       = DEF_TOKENS,
    parameter int                    tile_rows    = DEF_TILE_ROWS,
    parameter int                    drain_cycles = DEF_DRAIN_CYCLES,
    parameter int                    rd_latency   = 1,
    parameter logic [addr_width-1:0] q_base       = addr_width'(DEF_Q_BASE),
    parameter logic [addr_width-1:0] k_base       = addr_width'(DEF_K_BASE),
    parameter logic [addr_width-1:0] ch_stride    = addr_width'(DEF_CH_STRIDE)
) (
    input  logic              clk,
    input  logic              reset,
    qkv_tile_reader_if.master bus
);
    typedef logic [addr_width-1:0] addr_t;

    localparam int          nk        = num_ktiles(tokens, tile_rows);
    localparam logic [31:0] row_last  = 32'(tile_rows - 1);
    localparam logic [31:0] tok_last  = 32'(tokens - 1);
    localparam logic [31:0] drn_last  = 32'(drain_cycles - 1);
    localparam logic [31:0] kt_last   = 32'(nk - 1);
    localparam logic [31:0] ch_last   = 32'(num_ch - 1);
    localparam logic [31:0] tok_count = 32'(tokens);

    rd_state_t   state, state_n;
    logic [31:0] ch, ch_n, ktile, ktile_n, row, row_n, tok, tok_n, drn, drn_n;
    logic [31:0] n_next;
    addr_t       ch_off, iss_addr, rd_addr_q;
    logic        iss_rd, iss_wt, iss_pad, iss_last, stall;
    logic        rd_en_q, is_wt_q, pad_zero_q, tile_last_q, busy_q, done_q;

    // hold only freezes the active walk; IDLE and DONE always move on.
    assign stall = bus.hold && (state == ST_KLOAD || state == ST_QSTREAM || state == ST_DRAIN);

    // Next position in the channel/tile/row/token walk.
    always_comb begin
        state_n = state;
        ch_n    = ch;
        ktile_n = ktile;
        row_n   = row;
        tok_n   = tok;
        drn_n   = drn;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_KLOAD;
                    ch_n    = '0;
                    ktile_n = '0;
                    row_n   = '0;
                    tok_n   = '0;
                    drn_n   = '0;
                end
            end
            ST_KLOAD: begin
                if (row == row_last) begin
                    state_n = ST_QSTREAM;
                    tok_n   = '0;
                end else begin
                    row_n = row + 32'd1;
                end
            end
            ST_QSTREAM: begin
                if (tok == tok_last) begin
                    state_n = ST_DRAIN;
                    drn_n   = '0;
                end else begin
                    tok_n = tok + 32'd1;
                end
            end
            ST_DRAIN: begin
                if (drn == drn_last) begin
                    row_n = '0;
                    if (ktile != kt_last) begin
                        ktile_n = ktile + 32'd1;
                        state_n = ST_KLOAD;
                    end else if (ch != ch_last) begin
                        ch_n    = ch + 32'd1;
                        ktile_n = '0;
                        state_n = ST_KLOAD;
                    end else begin
                        state_n = ST_DONE;
                    end
                end else begin
                    drn_n = drn + 32'd1;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Decode the issue for the upcoming position so it can be registered this edge;
    // under hold it becomes the pending issue whose address is shown but not strobed.
    always_comb begin
        iss_rd   = 1'b0;
        iss_wt   = 1'b0;
        iss_pad  = 1'b0;
        iss_last = 1'b0;
        iss_addr = rd_addr_q;
        n_next   = ktile_n * 32'(tile_rows) + row_n;
        ch_off   = addr_t'(ch_n) * ch_stride;
        case (state_n)
            ST_KLOAD: begin
                iss_wt = 1'b1;
                if (n_next < tok_count) begin
                    iss_rd   = 1'b1;
                    iss_addr = k_base + ch_off + addr_t'(n_next);
                end else begin
                    iss_pad  = 1'b1;
                    iss_addr = '0;
                end
            end
            ST_QSTREAM: begin
                iss_rd   = 1'b1;
                iss_addr = q_base + ch_off + addr_t'(tok_n);
                iss_last = (tok_n == tok_last);
            end
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ch          <= '0;
            ktile       <= '0;
            row         <= '0;
            tok         <= '0;
            drn         <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            is_wt_q     <= 1'b0;
            pad_zero_q  <= 1'b0;
            tile_last_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (!stall) begin
                state <= state_n;
                ch    <= ch_n;
                ktile <= ktile_n;
                row   <= row_n;
                tok   <= tok_n;
                drn   <= drn_n;
            end
            rd_en_q     <= iss_rd && !stall;
            pad_zero_q  <= iss_pad && !stall;
            tile_last_q <= iss_last && !stall;
            is_wt_q     <= iss_wt;
            rd_addr_q   <= iss_addr;
            busy_q      <= stall || (state_n != ST_IDLE);
            done_q      <= !stall && (state_n == ST_DONE);
        end
    end

    valid_delay_line #(.depth(rd_latency)) u_delay (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_en_q),
        .in_is_wt (is_wt_q),
        .out_valid(bus.data_valid),
        .out_is_wt(bus.data_is_wt)
    );

    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.is_wt     = is_wt_q;
    assign bus.pad_zero  = pad_zero_q;
    assign bus.tile_last = tile_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_qkv_tile_reader.sv
// tb/tb_qkv_tile_reader.sv - scoreboard bench for qkv_tile_reader sequencing, hold, latency and reset
module tb_qkv_tile_reader;

    typedef struct {
        int          cyc;
        logic        pad;
        logic        wt;
        logic [31:0] addr;
        logic        last;
    } iss_t;

    iss_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    qkv_tile_reader_if #(.addr_width(32)) bus_a ();
    qkv_tile_reader_if #(.addr_width(32)) bus_b ();
    qkv_tile_reader_if #(.addr_width(32)) bus_c ();

    qkv_tile_reader #(.num_ch(2), .tokens(6), .tile_rows(4), .drain_cycles(3), .rd_latency(1))
        u_a (.clk(clk), .reset(reset), .bus(bus_a));
    qkv_tile_reader #(.num_ch(2), .tokens(6), .tile_rows(4), .drain_cycles(3), .rd_latency(2))
        u_b (.clk(clk), .reset(reset), .bus(bus_b));
    qkv_tile_reader #(.num_ch(3), .tokens(13), .tile_rows(4), .drain_cycles(19), .rd_latency(1))
        u_c (.clk(clk), .reset(reset), .bus(bus_c));

    // Expected issues for the small config (2 ch, 6 tokens, 4 rows, 3 drain -> 2 tiles/ch).
    // Issues whose nominal cycle is >= shift_at are delayed by shift cycles.
    task automatic push_pass(input int shift_at, input int shift, output int done_cyc);
        int   c;
        int   n;
        iss_t e;
        exp_q.delete();
        c = 1;
        for (int ch = 0; ch < 2; ch++) begin
            for (int kt = 0; kt < 2; kt++) begin
                for (int r = 0; r < 4; r++) begin
                    n      = kt * 4 + r;
                    e.cyc  = (c >= shift_at) ? c + shift : c;
                    e.pad  = (n >= 6);
                    e.wt   = 1'b1;
                    e.addr = (n < 6) ? 32'(32'h3000 + ch * 32'h300 + n) : 32'h0;
                    e.last = 1'b0;
                    exp_q.push_back(e);
                    c++;
                end
                for (int t = 0; t < 6; t++) begin
                    e.cyc  = (c >= shift_at) ? c + shift : c;
                    e.pad  = 1'b0;
                    e.wt   = 1'b0;
                    e.addr = 32'(ch * 32'h300 + t);
                    e.last = (t == 5);
                    exp_q.push_back(e);
                    c++;
                end
                c += 3;
            end
        end
        done_cyc = (c >= shift_at) ? c + shift : c;
    endtask

    task automatic run_pass_a(input string tag, input int hold_from, input int hold_len,
                              input int mid_start, input bit start_in_done);
        int   done_cyc;
        int   dones;
        iss_t e;
        push_pass((hold_len > 0) ? hold_from + 1 : 32'h3fff_ffff, hold_len, done_cyc);
        dones = 0;
        @(negedge clk);
        bus_a.start = 1'b1;
        for (int k = 1; k <= done_cyc + 4; k++) begin
            @(negedge clk);
            if (hold_len > 0 && k > hold_from && k <= hold_from + hold_len && exp_q.size() > 0) begin
                n_checks++;
                if (bus_a.rd_en !== 1'b0 || bus_a.rd_addr !== exp_q[0].addr) begin
                    n_fail++;
                    $display("FAIL %s_hold cyc=%0d rd_en=%b rd_addr=%h, required rd_en=0 rd_addr=%h",
                             tag, k, bus_a.rd_en, bus_a.rd_addr, exp_q[0].addr);
                end
            end
            if (bus_a.rd_en === 1'b1 || bus_a.pad_zero === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra_issue cyc=%0d rd_addr=%h, required no issue", tag, k, bus_a.rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (k != e.cyc || bus_a.rd_en !== !e.pad || bus_a.pad_zero !== e.pad ||
                        bus_a.is_wt !== e.wt || bus_a.rd_addr !== e.addr || bus_a.tile_last !== e.last) begin
                        n_fail++;
                        $display("FAIL %s_issue got cyc=%0d rd=%b pad=%b wt=%b addr=%h last=%b, required cyc=%0d rd=%b pad=%b wt=%b addr=%h last=%b",
                                 tag, k, bus_a.rd_en, bus_a.pad_zero, bus_a.is_wt, bus_a.rd_addr, bus_a.tile_last,
                                 e.cyc, !e.pad, e.pad, e.wt, e.addr, e.last);
                    end
                end
            end
            if (bus_a.done === 1'b1) begin
                n_checks++;
                dones++;
                if (k != done_cyc) begin
                    n_fail++;
                    $display("FAIL %s_done_cycle got %0d, required %0d", tag, k, done_cyc);
                end
            end
            bus_a.start = (k == mid_start) || (start_in_done && k == done_cyc);
            bus_a.hold  = (hold_len > 0) && (k >= hold_from) && (k < hold_from + hold_len);
        end
        n_checks++;
        if (dones != 1 || exp_q.size() != 0 || bus_a.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end dones=%0d left=%0d busy=%b, required dones=1 left=0 busy=0",
                     tag, dones, exp_q.size(), bus_a.busy);
        end
        bus_a.start = 1'b0;
        bus_a.hold  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus_a.rd_en, bus_a.rd_addr, bus_a.is_wt, bus_a.pad_zero, bus_a.data_valid,
             bus_a.data_is_wt, bus_a.tile_last, bus_a.busy, bus_a.done} !== 41'd0 ||
            bus_b.busy !== 1'b0 || bus_c.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs rd_en=%b addr=%h busy=%b done=%b dv=%b, required all 0",
                     bus_a.rd_en, bus_a.rd_addr, bus_a.busy, bus_a.done, bus_a.data_valid);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_pass();
        run_pass_a("basic", 0, 0, 0, 1'b0);
    endtask

    task automatic test_hold();
        run_pass_a("hold", 7, 5, 0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_pass_a("restart", 0, 0, 20, 1'b1);
    endtask

    task automatic test_latency();
        int   dc;
        bit   exp_rd [0:63];
        bit   exp_wt [0:63];
        iss_t e;
        for (int i = 0; i < 64; i++) begin
            exp_rd[i] = 1'b0;
            exp_wt[i] = 1'b0;
        end
        push_pass(32'h3fff_ffff, 0, dc);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_rd[e.cyc] = !e.pad;
            exp_wt[e.cyc] = e.wt;
        end
        @(negedge clk);
        bus_b.start = 1'b1;
        for (int k = 1; k <= dc + 3; k++) begin
            @(negedge clk);
            bus_b.start = 1'b0;
            n_checks++;
            if (bus_b.data_valid !== ((k >= 3) ? exp_rd[k-2] : 1'b0) ||
                bus_b.data_is_wt !== ((k >= 3) ? exp_wt[k-2] : 1'b0)) begin
                n_fail++;
                $display("FAIL latency2 cyc=%0d data_valid=%b data_is_wt=%b, required %b %b", k,
                         bus_b.data_valid, bus_b.data_is_wt,
                         (k >= 3) ? exp_rd[k-2] : 1'b0, (k >= 3) ? exp_wt[k-2] : 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int dones = 0;
        int issues = 0;
        @(negedge clk);
        bus_a.start = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            bus_a.start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_a.rd_en, bus_a.rd_addr, bus_a.is_wt, bus_a.pad_zero, bus_a.data_valid,
             bus_a.data_is_wt, bus_a.tile_last, bus_a.busy, bus_a.done} !== 41'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs rd_en=%b addr=%h wt=%b busy=%b dv=%b, required all 0",
                     bus_a.rd_en, bus_a.rd_addr, bus_a.is_wt, bus_a.busy, bus_a.data_valid);
        end
        reset = 1'b0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk);
            if (bus_a.done === 1'b1) dones++;
            if (bus_a.rd_en === 1'b1) issues++;
        end
        n_checks++;
        if (dones != 0 || issues != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet dones=%0d issues=%0d, required 0 0", dones, issues);
        end
        run_pass_a("replay", 0, 0, 0, 1'b0);
    endtask

    task automatic test_counts();
        int k_rd = 0;
        int q_rd = 0;
        int pads = 0;
        int dones = 0;
        int done_at = -1;
        int nk;
        int exp_done;
        nk       = (13 + 4 - 1) / 4;
        exp_done = 1 + 3 * nk * (4 + 13 + 19);
        @(negedge clk);
        bus_c.start = 1'b1;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            bus_c.start = 1'b0;
            if (bus_c.rd_en === 1'b1 && bus_c.is_wt === 1'b1) k_rd++;
            if (bus_c.rd_en === 1'b1 && bus_c.is_wt === 1'b0) q_rd++;
            if (bus_c.pad_zero === 1'b1) pads++;
            if (bus_c.done === 1'b1) begin
                dones++;
                done_at = k;
            end
        end
        n_checks++;
        if (k_rd != 3 * 13 || q_rd != 3 * nk * 13 || pads != 3 * (nk * 4 - 13)) begin
            n_fail++;
            $display("FAIL counts k=%0d q=%0d pad=%0d, required k=%0d q=%0d pad=%0d",
                     k_rd, q_rd, pads, 3 * 13, 3 * nk * 13, 3 * (nk * 4 - 13));
        end
        n_checks++;
        if (dones != 1 || done_at != exp_done) begin
            n_fail++;
            $display("FAIL count_done dones=%0d at=%0d, required 1 at %0d", dones, done_at, exp_done);
        end
    endtask

    initial begin
        bus_a.start = 1'b0;
        bus_a.hold  = 1'b0;
        bus_b.start = 1'b0;
        bus_b.hold  = 1'b0;
        bus_c.start = 1'b0;
        bus_c.hold  = 1'b0;
        test_reset();
        test_basic_pass();
        test_hold();
        test_start_ignored();
        test_latency();
        test_reset_mid_pass();
        test_counts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
